// File: rtl/dial_quad_gen.sv
// -----------------------------------------------------------------------------
// dial_quad_gen
//
// Multi-channel spinner/dial emulator. Each channel turns a pair of joystick
// direction levels (inc/dec) into a 2-bit quadrature phase that advances at a
// timed, accelerating rate. A shared prescaler produces the base tick. Each
// channel runs its own IDLE/RUN machine. Holding one direction starts slowly.
// The rate then shortens by one tick every ACCEL_STEPS steps, down to
// STEP_FAST.
//
// Ports:
//   clk_sys  - system clock
//   reset_n  - asynchronous active-low reset
//   en       - per-channel enable (quasi-static status bit)
//   invert   - per-channel swap of inc/dec meaning
//   inc      - clockwise request level, one bit per channel
//   dec      - counter-clockwise request level, one bit per channel
//   quad     - quadrature phase; channel n is at [2n+1:2n] = {A,B}
//   step     - one-cycle strobe when a channel's phase advances
//   dir      - direction of the channel's last step (1 = inc)
// -----------------------------------------------------------------------------
module dial_quad_gen #(
  parameter int CHANNELS    = 2,
  parameter int PRESC       = 12000,
  parameter int PRESC_W     = 16,
  parameter int STEP_SLOW   = 8,
  parameter int STEP_FAST   = 2,
  parameter int ACCEL_STEPS = 16,
  parameter int IV_W        = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   en,
  input  logic [CHANNELS-1:0]   invert,
  input  logic [CHANNELS-1:0]   inc,
  input  logic [CHANNELS-1:0]   dec,
  output logic [2*CHANNELS-1:0] quad,
  output logic [CHANNELS-1:0]   step,
  output logic [CHANNELS-1:0]   dir
);

  localparam int AC_W = $clog2(ACCEL_STEPS + 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // Gray-code walk: up goes 00->01->11->10->00, down is the reverse.
  function automatic logic [1:0] nextPhase(input logic [1:0] q, input logic up);
    logic [1:0] n;
    n = 2'b00;
    case (q)
      2'b00:   n = up ? 2'b01 : 2'b10;
      2'b01:   n = up ? 2'b11 : 2'b00;
      2'b11:   n = up ? 2'b10 : 2'b01;
      default: n = up ? 2'b00 : 2'b11;
    endcase
    return n;
  endfunction

  logic [PRESC_W-1:0] r_presc;
  logic               w_tick;

  assign w_tick = (r_presc == PRESC_W'(PRESC - 1));

  // Shared base-tick prescaler. It runs whether or not any channel is enabled,
  // so all channels see ticks on the same cycles.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    state_t          r_state, w_state_nxt;
    logic [IV_W-1:0] r_cnt, w_cnt_nxt;
    logic [IV_W-1:0] r_iv, w_iv_nxt;
    logic [AC_W-1:0] r_acc, w_acc_nxt;
    logic [1:0]      r_quad, w_quad_nxt;
    logic            r_step, w_step_nxt;
    logic            r_dir, w_dir_nxt;
    logic            r_reqdir, w_reqdir_nxt;
    logic            w_rinc, w_rdec, w_valid;
    logic [IV_W-1:0] w_iv_shrunk;

    assign w_rinc      = invert[g] ? dec[g] : inc[g];
    assign w_rdec      = invert[g] ? inc[g] : dec[g];
    assign w_valid     = en[g] & (w_rinc ^ w_rdec);
    assign w_iv_shrunk = (r_iv > IV_W'(STEP_FAST)) ? (r_iv - IV_W'(1)) : IV_W'(STEP_FAST);

    // Channel state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_iv     <= IV_W'(STEP_SLOW);
        r_acc    <= '0;
        r_quad   <= 2'b00;
        r_step   <= 1'b0;
        r_dir    <= 1'b0;
        r_reqdir <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_cnt    <= w_cnt_nxt;
        r_iv     <= w_iv_nxt;
        r_acc    <= w_acc_nxt;
        r_quad   <= w_quad_nxt;
        r_step   <= w_step_nxt;
        r_dir    <= w_dir_nxt;
        r_reqdir <= w_reqdir_nxt;
      end
    end

    // Next-state logic. The RUN exit check is done before any tick handling.
    // A reversal or release therefore never steps, and the channel restarts
    // slowly from IDLE. When the interval shrinks, the countdown reloads with
    // the new, shorter value straight away.
    always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_iv_nxt     = r_iv;
      w_acc_nxt    = r_acc;
      w_quad_nxt   = r_quad;
      w_step_nxt   = 1'b0;
      w_dir_nxt    = r_dir;
      w_reqdir_nxt = r_reqdir;
      unique case (r_state)
        ST_IDLE: begin
          if (w_tick && w_valid) begin
            w_state_nxt  = ST_RUN;
            w_cnt_nxt    = IV_W'(STEP_SLOW);
            w_iv_nxt     = IV_W'(STEP_SLOW);
            w_acc_nxt    = '0;
            w_reqdir_nxt = w_rinc;
            w_dir_nxt    = w_rinc;
            w_step_nxt   = 1'b1;
            w_quad_nxt   = nextPhase(r_quad, w_rinc);
          end
        end
        ST_RUN: begin
          if (!w_valid || (w_rinc != r_reqdir)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_iv_nxt    = IV_W'(STEP_SLOW);
            w_acc_nxt   = '0;
          end else if (w_tick) begin
            if (r_cnt == IV_W'(1)) begin
              w_step_nxt = 1'b1;
              w_dir_nxt  = r_reqdir;
              w_quad_nxt = nextPhase(r_quad, r_reqdir);
              if (r_acc == AC_W'(ACCEL_STEPS - 1)) begin
                w_acc_nxt = '0;
                w_iv_nxt  = w_iv_shrunk;
                w_cnt_nxt = w_iv_shrunk;
              end else begin
                w_acc_nxt = r_acc + AC_W'(1);
                w_cnt_nxt = r_iv;
              end
            end else begin
              w_cnt_nxt = r_cnt - IV_W'(1);
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    assign quad[2*g +: 2] = r_quad;
    assign step[g]        = r_step;
    assign dir[g]         = r_dir;
  end

endmodule
